// File: rtl/recv_fifo_pkg.sv
// ---------------------------------------------------------------------------
// recv_fifo_pkg
//   Shared constants for the UART receive FIFO.
//   - UART_DATA_W     : received character width
//   - RX_FIFO_DEPTH   : FIFO entries (power of two, >= 4)
//   - RX_FIFO_AW      : pointer width, log2(RX_FIFO_DEPTH)
//   - RX_AFULL_THRESH : almost_full threshold on count
//   - RX_ENTRY_W      : stored entry width, framing-error bit in the MSB
// ---------------------------------------------------------------------------
package recv_fifo_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int RX_FIFO_DEPTH   = 16;
  localparam int RX_FIFO_AW      = 4;
  localparam int RX_AFULL_THRESH = 12;
  localparam int RX_ENTRY_W      = UART_DATA_W + 1;

  // One stored character: {ferr, data}
  typedef logic [RX_ENTRY_W-1:0] rx_entry_t;

  function automatic rx_entry_t pack_entry(input logic ferr,
                                           input logic [UART_DATA_W-1:0] data);
    return {ferr, data};
  endfunction

endpackage

// File: rtl/recv_fifo_if.sv
// ---------------------------------------------------------------------------
// recv_fifo_if
//   Bundles the receiver-side write strobe, the host-side read request and
//   all FIFO status outputs.
//   master : driven by receiver/host (rx_done, rx_data, rx_ferr, rd_en,
//            clr_overrun), observes data and status
//   slave  : the FIFO itself
// ---------------------------------------------------------------------------
interface recv_fifo_if
  import recv_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int AW     = RX_FIFO_AW
);

  logic              rx_done;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ferr;
  logic              rd_en;
  logic              clr_overrun;
  logic [DATA_W-1:0] dout;
  logic              dout_ferr;
  logic              dout_valid;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [AW:0]       count;
  logic              overrun;

  modport master (
    output rx_done, rx_data, rx_ferr, rd_en, clr_overrun,
    input  dout, dout_ferr, dout_valid, empty, full, almost_full, count, overrun
  );

  modport slave (
    input  rx_done, rx_data, rx_ferr, rd_en, clr_overrun,
    output dout, dout_ferr, dout_valid, empty, full, almost_full, count, overrun
  );

endinterface

// File: rtl/recv_fifo_mem_2p.sv
// ---------------------------------------------------------------------------
// fifo_mem_2p
//   Simple dual-port storage: one synchronous write port, one synchronous
//   read port with enable. Read data is registered and holds while rd_en is
//   low. A read and write to the same address in one cycle returns the old
//   contents (read-before-write), which the full+read case relies on.
//   Ports: clk, wr_en/wr_addr/wr_data, rd_en/rd_addr, rd_data.
//   Storage and read register are not reset so they map to block RAM.
// ---------------------------------------------------------------------------
module fifo_mem_2p #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/recv_fifo.sv
// ---------------------------------------------------------------------------
// recv_fifo
//   UART receive-side FIFO. Stores each received character with its
//   framing-error bit, provides occupancy flags and a sticky overrun flag.
//   Ports:
//     clk       : system clock, rising edge
//     areset_n  : asynchronous active-low reset
//     bus       : recv_fifo_if.slave (write strobe, read request, data out,
//                 empty/full/almost_full/count, overrun, clr_overrun)
// ---------------------------------------------------------------------------
module recv_fifo
  import recv_fifo_pkg::*;
#(
  parameter int DATA_W       = UART_DATA_W,
  parameter int DEPTH        = RX_FIFO_DEPTH,
  parameter int AW           = RX_FIFO_AW,
  parameter int AFULL_THRESH = RX_AFULL_THRESH
) (
  input logic         clk,
  input logic         areset_n,
  recv_fifo_if.slave  bus
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_THRESH);

  logic [AW-1:0] wptr_reg, rptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          overrun_reg, overrun_next;
  logic          dout_valid_reg;
  // Set by the first accepted read after reset; until then the (unreset)
  // memory read register is masked so dout reads as zero.
  logic          dout_loaded_reg;

  logic          empty_w, full_w;
  logic          wr_accept, rd_accept, drop;
  logic [DATA_W:0] wr_entry, rd_entry;

  assign empty_w = (count_reg == '0);
  assign full_w  = (count_reg == DEPTH_C);

  // When full, a concurrent read frees the slot being written this cycle.
  assign rd_accept = bus.rd_en && !empty_w;
  assign wr_accept = bus.rx_done && (!full_w || bus.rd_en);
  assign drop      = bus.rx_done && full_w && !bus.rd_en;

  assign wr_entry = {bus.rx_ferr, bus.rx_data};

  fifo_mem_2p #(
    .WIDTH (DATA_W+1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wptr_reg),
    .wr_data (wr_entry),
    .rd_en   (rd_accept),
    .rd_addr (rptr_reg),
    .rd_data (rd_entry)
  );

  always_comb begin
    count_next = count_reg;
    if (wr_accept && !rd_accept)      count_next = count_reg + 1'b1;
    else if (rd_accept && !wr_accept) count_next = count_reg - 1'b1;
  end

  // Drop takes priority over a same-cycle clear.
  always_comb begin
    overrun_next = overrun_reg;
    if (drop)                 overrun_next = 1'b1;
    else if (bus.clr_overrun) overrun_next = 1'b0;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wptr_reg        <= '0;
      rptr_reg        <= '0;
      count_reg       <= '0;
      overrun_reg     <= 1'b0;
      dout_valid_reg  <= 1'b0;
      dout_loaded_reg <= 1'b0;
    end else begin
      if (wr_accept) wptr_reg <= wptr_reg + 1'b1;
      if (rd_accept) rptr_reg <= rptr_reg + 1'b1;
      count_reg      <= count_next;
      overrun_reg    <= overrun_next;
      dout_valid_reg <= rd_accept;
      if (rd_accept) dout_loaded_reg <= 1'b1;
    end
  end

  assign bus.dout        = dout_loaded_reg ? rd_entry[DATA_W-1:0] : '0;
  assign bus.dout_ferr   = dout_loaded_reg ? rd_entry[DATA_W]     : 1'b0;
  assign bus.dout_valid  = dout_valid_reg;
  assign bus.empty       = empty_w;
  assign bus.full        = full_w;
  assign bus.almost_full = (count_reg >= AFULL_C);
  assign bus.count       = count_reg;
  assign bus.overrun     = overrun_reg;

endmodule
